// File: rtl/mel_divider.sv
// Iterative restoring divider: quot = (num << FRAC_BITS) / den, one quotient bit per cycle.
// Quotient saturates to all-ones on overflow or divide-by-zero; results are held until out_ready.
module mel_divider #(
  parameter int N_WIDTH   = 32,
  parameter int D_WIDTH   = 16,
  parameter int Q_WIDTH   = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_WIDTH-1:0] num,
  input  logic [D_WIDTH-1:0] den,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Q_WIDTH-1:0] quot,
  output logic [D_WIDTH-1:0] rem,
  output logic               div_zero,
  output logic               overflow,
  output logic [1:0]         fsm_state
);

  // Handshakes: a transfer happens on an edge where valid and ready are both high;
  // valid never drops and its payload never changes until that transfer.

  localparam int W  = N_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [W-1:0]       dividend;
  logic [W-1:0]       q;
  logic [D_WIDTH-1:0] divisor;
  logic [D_WIDTH:0]   r;
  logic [CW-1:0]      count;

  logic [D_WIDTH:0]   r_shift;
  logic [D_WIDTH:0]   r_next;
  logic               q_bit;
  logic [W-1:0]       q_next;

  assign fsm_state = state;

  // One restoring step; the partial remainder is always below den, so D_WIDTH+1 bits suffice.
  always_comb begin
    r_shift = {r[D_WIDTH-1:0], dividend[W-1]};
    q_bit   = (r_shift >= {1'b0, divisor});
    r_next  = q_bit ? (r_shift - {1'b0, divisor}) : r_shift;
    q_next  = {q[W-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      dividend  <= '0;
      q         <= '0;
      divisor   <= '0;
      r         <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dividend <= {num, {FRAC_BITS{1'b0}}};
            divisor  <= den;
            r        <= '0;
            q        <= '0;
            in_ready <= 1'b0;
            if (den != '0) begin
              state <= CALC;
              count <= CW'(W);
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              quot      <= '1;
              rem       <= '0;
              div_zero  <= 1'b1;
              overflow  <= 1'b0;
            end
          end
        end
        CALC: begin
          dividend <= dividend << 1;
          r        <= r_next;
          q        <= q_next;
          count    <= count - CW'(1);
          if (count == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            div_zero  <= 1'b0;
            rem       <= r_next[D_WIDTH-1:0];
            if (|q_next[W-1:Q_WIDTH]) begin
              quot     <= '1;
              overflow <= 1'b1;
            end else begin
              quot     <= q_next[Q_WIDTH-1:0];
              overflow <= 1'b0;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mel_divider.sv
// Directed bench for mel_divider: hand-computed quotients, latency, flags, backpressure and reset abort.
module tb_mel_divider;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] num;
  logic [15:0] den;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic [15:0] rem;
  logic        div_zero;
  logic        overflow;
  logic [1:0]  fsm_state;

  int checks;
  int errors;

  mel_divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .den       (den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .div_zero  (div_zero),
    .overflow  (overflow),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, then presents operands for exactly one accepting edge.
  task automatic start_op(input logic [31:0] n, input logic [15:0] d);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      step();
      guard++;
    end
    num      = n;
    den      = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid; returns 999 on timeout.
  task automatic wait_result(output int cycles, output logic busy_ok);
    cycles  = 0;
    busy_ok = 1'b1;
    while (!out_valid && cycles < 200) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      step();
      cycles++;
    end
    if (!out_valid) cycles = 999;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    checks++;
    if (quot !== 16'h0 || rem !== 16'h0 || div_zero !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: quot=%h rem=%h dz=%b ov=%b, required all 0", quot, rem, div_zero, overflow);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int cyc;
    logic busy_ok;
    start_op(32'd100, 16'd4);
    wait_result(cyc, busy_ok);
    checks++;
    if (cyc != 40) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges, required 40", cyc);
    end
    checks++;
    if (quot !== 16'h1900 || rem !== 16'd0 || div_zero !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: quot=%h rem=%0d dz=%b ov=%b, required 1900 0 0 0", quot, rem, div_zero, overflow);
    end
    step();
  endtask

  task automatic test_ignore_busy();
    int cyc;
    logic busy_ok;
    logic extra;
    start_op(32'd7, 16'd3);
    for (int i = 0; i < 5; i++) step();
    num      = 32'd1000;
    den      = 16'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    num      = 32'd12345;
    wait_result(cyc, busy_ok);
    checks++;
    if (busy_ok !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_ready: in_ready seen high during CALC, required 0");
    end
    checks++;
    if (cyc != 34) begin
      errors++;
      $display("FAIL busy_latency: got %0d remaining edges, required 34", cyc);
    end
    checks++;
    if (quot !== 16'd597 || rem !== 16'd1) begin
      errors++;
      $display("FAIL busy_result: quot=%0d rem=%0d, required 597 1", quot, rem);
    end
    step();
    extra = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) extra = 1'b1;
      step();
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("FAIL busy_single_result: extra out_valid seen, required none");
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    logic busy_ok;
    start_op(32'd5, 16'd0);
    wait_result(cyc, busy_ok);
    checks++;
    if (cyc != 0) begin
      errors++;
      $display("FAIL dz_latency: got %0d extra edges, required 0 (1 after acceptance)", cyc);
    end
    checks++;
    if (quot !== 16'hFFFF || rem !== 16'd0 || div_zero !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL dz_result: quot=%h rem=%0d dz=%b ov=%b, required ffff 0 1 0", quot, rem, div_zero, overflow);
    end
    step();
  endtask

  task automatic test_overflow();
    int cyc;
    logic busy_ok;
    start_op(32'h0001_0000, 16'd1);
    wait_result(cyc, busy_ok);
    checks++;
    if (quot !== 16'hFFFF || overflow !== 1'b1 || div_zero !== 1'b0 || cyc != 40) begin
      errors++;
      $display("FAIL ovf_result: quot=%h ov=%b dz=%b cyc=%0d, required ffff 1 0 40", quot, overflow, div_zero, cyc);
    end
    step();
    start_op(32'd255, 16'd1);
    wait_result(cyc, busy_ok);
    checks++;
    if (quot !== 16'hFF00 || overflow !== 1'b0 || rem !== 16'd0) begin
      errors++;
      $display("FAIL ovf_edge: quot=%h ov=%b rem=%0d, required ff00 0 0", quot, overflow, rem);
    end
    step();
    start_op(32'd0, 16'd7);
    wait_result(cyc, busy_ok);
    checks++;
    if (quot !== 16'd0 || rem !== 16'd0 || cyc != 40) begin
      errors++;
      $display("FAIL zero_num: quot=%0d rem=%0d cyc=%0d, required 0 0 40", quot, rem, cyc);
    end
    step();
  endtask

  task automatic test_backpressure();
    int cyc;
    logic busy_ok;
    logic stable;
    out_ready = 1'b0;
    start_op(32'd1000, 16'd7);
    wait_result(cyc, busy_ok);
    checks++;
    if (quot !== 16'd36571 || rem !== 16'd3) begin
      errors++;
      $display("FAIL bp_result: quot=%0d rem=%0d, required 36571 3", quot, rem);
    end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid !== 1'b1 || quot !== 16'd36571 || rem !== 16'd3 || in_ready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: outputs changed while out_ready=0, required stable");
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    checks++;
    if (quot !== 16'd36571 || rem !== 16'd3) begin
      errors++;
      $display("FAIL bp_retain: quot=%0d rem=%0d, required 36571 3", quot, rem);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    logic busy_ok;
    start_op(32'd100, 16'd4);
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quot !== 16'd0) begin
      errors++;
      $display("FAIL abort_reset: in_ready=%b out_valid=%b quot=%0d, required 1 0 0", in_ready, out_valid, quot);
    end
    start_op(32'd9, 16'd3);
    wait_result(cyc, busy_ok);
    checks++;
    if (quot !== 16'd768 || rem !== 16'd0 || cyc != 40) begin
      errors++;
      $display("FAIL abort_next: quot=%0d rem=%0d cyc=%0d, required 768 0 40", quot, rem, cyc);
    end
    step();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    num       = '0;
    den       = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_ignore_busy();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
